// File: rtl/uart_frame_tx_if.sv
// Byte-request / serial-line bundle between a frame requester and uart_frame_tx.
interface uart_frame_tx_if;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       cts;
  logic       tx_line;
  logic       tx_busy;
  logic       tx_done;

  modport master (
    output tx_data, tx_start, cts,
    input  tx_line, tx_busy, tx_done
  );

  modport slave (
    input  tx_data, tx_start, cts,
    output tx_line, tx_busy, tx_done
  );
endinterface

// File: rtl/uart_frame_tx.sv
// UART frame transmitter: start bit, 8 data bits LSB-first, optional even parity,
// one stop bit; requests accepted only in IDLE while the far end asserts cts.
module uart_frame_tx #(
  parameter int unsigned CLKS_PER_BIT = 5208,
  parameter bit          PARITY_EN    = 1'b0
) (
  input logic            clock,
  input logic            reset,
  uart_frame_tx_if.slave bus
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_PRELAST = CNT_W'(CLKS_PER_BIT - 2);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             par_q, par_d;
  logic             line_q, line_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             bit_end_c;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      line_q  <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      line_q  <= line_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next state; the baud counter restarts on every state change so bits never drift.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    par_d     = par_q;
    bit_end_c = (cnt_q == CNT_LAST);

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (bus.tx_start && bus.cts) begin
          state_d = START;
          shift_d = bus.tx_data;
          par_d   = ^bus.tx_data;
        end
      end
      START: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (bit_end_c) begin
          state_d = DATA;
          cnt_d   = '0;
          bit_d   = '0;
        end
      end
      DATA: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (bit_end_c) begin
          cnt_d = '0;
          if (bit_q == 3'd7) begin
            state_d = PARITY_EN ? PARITY : STOP;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = shift_q >> 1;
          end
        end
      end
      PARITY: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (bit_end_c) begin
          state_d = STOP;
          cnt_d   = '0;
        end
      end
      STOP: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (bit_end_c) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are registered from the next state so the line changes on the decision edge.
  always_comb begin
    line_d = 1'b1;
    case (state_d)
      START:   line_d = 1'b0;
      DATA:    line_d = shift_d[0];
      PARITY:  line_d = par_d;
      default: line_d = 1'b1;
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_q == STOP) && (cnt_q == CNT_PRELAST);
  end

  assign bus.tx_line = line_q;
  assign bus.tx_busy = busy_q;
  assign bus.tx_done = done_q;

endmodule

// File: tb/tb_uart_frame_tx.sv
// Directed + randomized bench for uart_frame_tx: one instance without parity, one with.
module tb_uart_frame_tx;

  localparam int CLKS = 4;

  logic clock = 1'b0;
  logic reset;

  logic [1:0] start_v;
  logic [1:0] cts_v;
  logic [7:0] data_v [2];
  logic [1:0] line_w, busy_w, done_w;

  int vectors     = 0;
  int miscompares = 0;

  uart_frame_tx_if bus0 ();
  uart_frame_tx_if bus1 ();

  assign bus0.tx_start = start_v[0];
  assign bus0.cts      = cts_v[0];
  assign bus0.tx_data  = data_v[0];
  assign bus1.tx_start = start_v[1];
  assign bus1.cts      = cts_v[1];
  assign bus1.tx_data  = data_v[1];
  assign line_w = {bus1.tx_line, bus0.tx_line};
  assign busy_w = {bus1.tx_busy, bus0.tx_busy};
  assign done_w = {bus1.tx_done, bus0.tx_done};

  uart_frame_tx #(.CLKS_PER_BIT(CLKS), .PARITY_EN(1'b0)) dut0 (
    .clock (clock),
    .reset (reset),
    .bus   (bus0)
  );

  uart_frame_tx #(.CLKS_PER_BIT(CLKS), .PARITY_EN(1'b1)) dut1 (
    .clock (clock),
    .reset (reset),
    .bus   (bus1)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Reference frame: bit period idx = k / CLKS; 0=start, 1..8=data LSB-first, then parity/stop.
  function automatic logic exp_line(input logic [7:0] b, input bit pe, input int k);
    int idx;
    idx = k / CLKS;
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
    if (pe && idx == 9) return ^b;
    return 1'b1;
  endfunction

  task automatic launch(input int sel, input logic [7:0] b);
    data_v[sel]  = b;
    start_v[sel] = 1'b1;
    cts_v[sel]   = 1'b1;
    @(negedge clock);
  endtask

  // Called at cycle 0 of a frame; ends at cycle 0 after the first idle cycle.
  task automatic check_frame(input int sel, input logic [7:0] b, input bit hold,
                             input bit drop_cts, input int chg_cycle, input logic [7:0] chg_val);
    int len;
    len = (10 + sel) * CLKS;
    for (int k = 0; k < len; k++) begin
      if (k == 0 && !hold) start_v[sel] = 1'b0;
      if (k == 2 * CLKS && drop_cts) cts_v[sel] = 1'b0;
      if (k == chg_cycle) data_v[sel] = chg_val;
      chk($sformatf("line%0d_b%02h_c%0d", sel, b, k), line_w[sel], exp_line(b, sel == 1, k));
      chk($sformatf("busy%0d_b%02h_c%0d", sel, b, k), busy_w[sel], 1'b1);
      chk($sformatf("done%0d_b%02h_c%0d", sel, b, k), done_w[sel], (k == len - 1));
      @(negedge clock);
    end
    chk($sformatf("gapline%0d_b%02h", sel, b), line_w[sel], 1'b1);
    chk($sformatf("gapbusy%0d_b%02h", sel, b), busy_w[sel], 1'b0);
    chk($sformatf("gapdone%0d_b%02h", sel, b), done_w[sel], 1'b0);
    @(negedge clock);
  endtask

  initial begin
    logic [7:0] rb;
    int         rs;

    reset      = 1'b1;
    start_v    = '0;
    cts_v      = '0;
    data_v[0]  = '0;
    data_v[1]  = '0;
    repeat (2) @(negedge clock);
    for (int s = 0; s < 2; s++) begin
      chk($sformatf("rst_line%0d", s), line_w[s], 1'b1);
      chk($sformatf("rst_busy%0d", s), busy_w[s], 1'b0);
      chk($sformatf("rst_done%0d", s), done_w[s], 1'b0);
    end
    reset = 1'b0;

    // Idle stability.
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      chk($sformatf("idle_line_c%0d", k), line_w[0], 1'b1);
      chk($sformatf("idle_busy_c%0d", k), busy_w[0], 1'b0);
      chk($sformatf("idle_done_c%0d", k), done_w[0], 1'b0);
    end

    launch(0, 8'hA5);
    check_frame(0, 8'hA5, 1'b0, 1'b0, -1, 8'h00);

    launch(1, 8'h07);
    check_frame(1, 8'h07, 1'b0, 1'b0, -1, 8'h00);
    launch(1, 8'h03);
    check_frame(1, 8'h03, 1'b0, 1'b0, -1, 8'h00);

    // Request held while cts is low must not launch.
    data_v[0]  = 8'hC3;
    start_v[0] = 1'b1;
    cts_v[0]   = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      chk($sformatf("nocts_line_c%0d", k), line_w[0], 1'b1);
      chk($sformatf("nocts_busy_c%0d", k), busy_w[0], 1'b0);
    end
    cts_v[0] = 1'b1;
    @(negedge clock);
    check_frame(0, 8'hC3, 1'b0, 1'b1, -1, 8'h00);

    // Back-to-back with held request; data change mid-frame ignored until next accept.
    launch(0, 8'h55);
    check_frame(0, 8'h55, 1'b1, 1'b0, 20, 8'hFF);
    check_frame(0, 8'hFF, 1'b0, 1'b0, -1, 8'h00);

    // Randomized frames on both instances.
    for (int i = 0; i < 6; i++) begin
      rb = 8'($urandom);
      rs = i % 2;
      launch(rs, rb);
      check_frame(rs, rb, 1'b0, 1'($urandom_range(0, 1)), -1, 8'h00);
    end

    // Reset during data bit 3 aborts the frame.
    launch(0, 8'h00);
    start_v[0] = 1'b0;
    repeat (4 * CLKS + 1) @(negedge clock);
    chk("mid_line_before_rst", line_w[0], 1'b0);
    chk("mid_busy_before_rst", busy_w[0], 1'b1);
    reset = 1'b1;
    @(negedge clock);
    chk("abort_line", line_w[0], 1'b1);
    chk("abort_busy", busy_w[0], 1'b0);
    chk("abort_done", done_w[0], 1'b0);
    reset = 1'b0;
    for (int k = 0; k < 3 * CLKS; k++) begin
      @(negedge clock);
      chk($sformatf("post_rst_line_c%0d", k), line_w[0], 1'b1);
      chk($sformatf("post_rst_done_c%0d", k), done_w[0], 1'b0);
    end
    rb = 8'($urandom);
    launch(0, rb);
    check_frame(0, rb, 1'b0, 1'b0, -1, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
